// File: rtl/ysyx_22041211_lsu.sv
// Load/store stage: performs at most one data-memory access per execute result,
// aligning stores onto byte lanes and extracting/extending loads for writeback.
module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                mem_wen_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                dmem_req,
  input  logic                dmem_gnt,
  output logic [DATA_LEN-1:0] dmem_addr,
  output logic                dmem_wen,
  output logic [3:0]          dmem_wstrb,
  output logic [DATA_LEN-1:0] dmem_wdata,
  input  logic                dmem_rvalid,
  input  logic [DATA_LEN-1:0] dmem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [1:0] ST_SB  = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
  localparam logic [2:0] LD_LB  = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4, LD_LHU = 3'd5;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                wd_q, wd_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic                misalign_q, misalign_d;
  logic                req_q, req_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_LEN-1:0] mwdata_q, mwdata_d;
  logic [2:0]          load_type_q, load_type_d;
  logic [1:0]          off_q, off_d;

  logic                capture, is_store, is_load, is_mem, misaligned;
  logic [1:0]          off_i;
  logic [3:0]          st_wstrb;
  logic [DATA_LEN-1:0] st_wdata, ld_data;
  logic [7:0]          byte_val;
  logic [15:0]         half_val;

  always_comb begin
    off_i      = alu_result_i[1:0];
    is_store   = mem_wen_i;
    is_load    = !mem_wen_i && (load_type_i >= LD_LB) && (load_type_i <= LD_LHU);
    is_mem     = is_store || is_load;
    misaligned = 1'b0;
    st_wstrb   = 4'b0000;
    st_wdata   = '0;
    if (is_store) begin
      case (store_type_i)
        ST_SB: begin
          st_wstrb = 4'b0001 << off_i;
          st_wdata = {4{mem_wdata_i[7:0]}};
        end
        ST_SH: begin
          st_wstrb   = 4'b0011 << off_i;
          st_wdata   = {2{mem_wdata_i[15:0]}};
          misaligned = off_i[0];
        end
        ST_SW: begin
          st_wstrb   = 4'b1111;
          st_wdata   = mem_wdata_i;
          misaligned = (off_i != 2'b00);
        end
        default: ;
      endcase
    end else if (is_load) begin
      if (load_type_i == LD_LH || load_type_i == LD_LHU) misaligned = off_i[0];
      if (load_type_i == LD_LW) misaligned = (off_i != 2'b00);
    end
  end

  // Lane selection uses the byte offset remembered from the captured address.
  always_comb begin
    byte_val = dmem_rdata[{off_q, 3'b000} +: 8];
    half_val = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (load_type_q)
      LD_LB:   ld_data = {{24{byte_val[7]}}, byte_val};
      LD_LBU:  ld_data = {24'h0, byte_val};
      LD_LH:   ld_data = {{16{half_val[15]}}, half_val};
      LD_LHU:  ld_data = {16'h0, half_val};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    capture     = in_valid && in_ready;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    misalign_d  = misalign_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wstrb_d     = wstrb_q;
    mwdata_d    = mwdata_q;
    load_type_d = load_type_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          misalign_d  = 1'b0;
        end
        if (capture) begin
          wreg_d = wreg_i;
          if (!is_mem) begin
            out_valid_d = 1'b1;
            wd_d        = wd_i;
            wdata_d     = alu_result_i;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            wd_d        = 1'b0;
            wdata_d     = '0;
            misalign_d  = 1'b1;
          end else begin
            state_d     = REQ;
            wd_d        = wd_i;
            req_d       = 1'b1;
            addr_d      = {alu_result_i[DATA_LEN-1:2], 2'b00};
            wen_d       = is_store;
            wstrb_d     = st_wstrb;
            mwdata_d    = st_wdata;
            load_type_d = load_type_i;
            off_d       = off_i;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          wdata_d     = wen_q ? '0 : ld_data;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      wd_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      misalign_q  <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wstrb_q     <= '0;
      mwdata_q    <= '0;
      load_type_q <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wstrb_q     <= wstrb_d;
      mwdata_q    <= mwdata_d;
      load_type_q <= load_type_d;
      off_q       <= off_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign wdata_o    = wdata_q;
  assign misalign_o = misalign_q;
  assign dmem_req   = req_q;
  assign dmem_addr  = addr_q;
  assign dmem_wen   = wen_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = mwdata_q;
endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed testbench for ysyx_22041211_lsu: ALU pass-through, stores, loads,
// bus stalls, misalignment, output backpressure and reset during an access.
module tb_ysyx_22041211_lsu;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_result_i, mem_wdata_i;
  logic        mem_wen_i;
  logic [1:0]  store_type_i;
  logic [2:0]  load_type_i;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic        dmem_req, dmem_gnt, dmem_wen, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        out_valid, out_ready, wd_o, misalign_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;

  int errors = 0;
  int checks = 0;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_i(alu_result_i), .mem_wen_i(mem_wen_i), .mem_wdata_i(mem_wdata_i),
    .store_type_i(store_type_i), .load_type_i(load_type_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    in_valid = 0; alu_result_i = 0; mem_wen_i = 0; mem_wdata_i = 0;
    store_type_i = 0; load_type_i = 0; wd_i = 0; wreg_i = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmem_req: got %b want 0", dmem_req); end
    checks++; if (wdata_o !== 32'h0 || wreg_o !== 5'd0 || wd_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_bundle: got wdata=%h wreg=%0d wd=%b want zeros", wdata_o, wreg_o, wd_o); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0 || dmem_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_dmem: got addr=%h wdata=%h wstrb=%b wen=%b want zeros", dmem_addr, dmem_wdata, dmem_wstrb, dmem_wen); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu();
    in_valid = 1; alu_result_i = 32'h1234; wreg_i = 5; wd_i = 1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_out_valid: got %b want 1", out_valid); end
    checks++; if (wdata_o !== 32'h1234 || wreg_o !== 5'd5 || wd_o !== 1'b1) begin errors++; $display("[TB] FAIL alu_bundle: got wdata=%h wreg=%0d wd=%b want 1234/5/1", wdata_o, wreg_o, wd_o); end
    checks++; if (dmem_req !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL alu_no_mem: got req=%b misalign=%b want 0/0", dmem_req, misalign_o); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; alu_result_i = 32'h11; wreg_i = 1; wd_i = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h11 || wreg_o !== 5'd1) begin errors++; $display("[TB] FAIL b2b_first: got v=%b wdata=%h wreg=%0d want 1/11/1", out_valid, wdata_o, wreg_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b want 1", in_ready); end
    alu_result_i = 32'h22; wreg_i = 2;
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h22 || wreg_o !== 5'd2) begin errors++; $display("[TB] FAIL b2b_second: got v=%b wdata=%h wreg=%0d want 1/22/2", out_valid, wdata_o, wreg_o); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_store();
    logic [31:0] addr [4];
    logic [31:0] data [4];
    logic [1:0]  st   [4];
    logic [2:0]  lt   [4];
    logic [31:0] exp_addr [4];
    logic [3:0]  exp_strb [4];
    logic [31:0] exp_data [4];
    addr = '{32'h8000_0003, 32'h1000_0002, 32'h2000_0004, 32'h3000_0001};
    data = '{32'h0000_00AB, 32'h0000_BEEF, 32'hDEAD_BEEF, 32'h0000_005A};
    st   = '{2'd1, 2'd2, 2'd3, 2'd1};
    lt   = '{3'd0, 3'd0, 3'd1, 3'd0};
    exp_addr = '{32'h8000_0000, 32'h1000_0000, 32'h2000_0004, 32'h3000_0000};
    exp_strb = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    exp_data = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hDEAD_BEEF, 32'h5A5A_5A5A};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; mem_wen_i = 1; alu_result_i = addr[i]; mem_wdata_i = data[i];
      store_type_i = st[i]; load_type_i = lt[i]; wd_i = 0; wreg_i = 0;
      @(negedge clk);
      in_valid = 0; mem_wen_i = 0; store_type_i = 0; load_type_i = 0;
      checks++; if (dmem_req !== 1'b1 || dmem_wen !== 1'b1) begin errors++; $display("[TB] FAIL store%0d_req: got req=%b wen=%b want 1/1", i, dmem_req, dmem_wen); end
      checks++; if (dmem_addr !== exp_addr[i] || dmem_wstrb !== exp_strb[i] || dmem_wdata !== exp_data[i]) begin errors++; $display("[TB] FAIL store%0d_bus: got addr=%h wstrb=%b wdata=%h want %h/%b/%h", i, dmem_addr, dmem_wstrb, dmem_wdata, exp_addr[i], exp_strb[i], exp_data[i]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL store%0d_in_ready: got %b want 0", i, in_ready); end
      dmem_gnt = 1;
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 1;
      checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL store%0d_resp: got req=%b v=%b want 0/0", i, dmem_req, out_valid); end
      @(negedge clk);
      dmem_rvalid = 0;
      checks++; if (out_valid !== 1'b1 || wd_o !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL store%0d_done: got v=%b wd=%b mis=%b want 1/0/0", i, out_valid, wd_o, misalign_o); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL store%0d_idle: got v=%b ready=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_load();
    logic [31:0] addr  [6];
    logic [2:0]  lt    [6];
    logic [31:0] rdata [6];
    logic [31:0] exp_addr [6];
    logic [31:0] exp_wd   [6];
    addr  = '{32'h0000_0102, 32'h0000_0102, 32'h0000_0202, 32'h0000_0300, 32'h0000_0408, 32'h0000_0501};
    lt    = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd1};
    rdata = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h1234_8765, 32'hCAFE_F00D, 32'h0000_7F00};
    exp_addr = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0408, 32'h0000_0500};
    exp_wd   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8765, 32'hCAFE_F00D, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; mem_wen_i = 0; alu_result_i = addr[i]; load_type_i = lt[i]; wd_i = 1; wreg_i = 7;
      @(negedge clk);
      in_valid = 0; load_type_i = 0;
      checks++; if (dmem_req !== 1'b1 || dmem_wen !== 1'b0 || dmem_wstrb !== 4'b0000 || dmem_addr !== exp_addr[i]) begin errors++; $display("[TB] FAIL load%0d_bus: got req=%b wen=%b wstrb=%b addr=%h want 1/0/0000/%h", i, dmem_req, dmem_wen, dmem_wstrb, dmem_addr, exp_addr[i]); end
      dmem_gnt = 1;
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata[i];
      @(negedge clk);
      dmem_rvalid = 0; dmem_rdata = 0;
      checks++; if (out_valid !== 1'b1 || wdata_o !== exp_wd[i]) begin errors++; $display("[TB] FAIL load%0d_data: got v=%b wdata=%h want 1/%h", i, out_valid, wdata_o, exp_wd[i]); end
      checks++; if (wd_o !== 1'b1 || wreg_o !== 5'd7) begin errors++; $display("[TB] FAIL load%0d_rd: got wd=%b wreg=%0d want 1/7", i, wd_o, wreg_o); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_drain: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_stall_backpressure();
    in_valid = 1; alu_result_i = 32'h4000_0010; load_type_i = 3'd3; wd_i = 1; wreg_i = 9;
    @(negedge clk);
    in_valid = 0; load_type_i = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h4000_0010 || dmem_wen !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_req%0d: got req=%b addr=%h wen=%b ready=%b want 1/40000010/0/0", i, dmem_req, dmem_addr, dmem_wen, in_ready); end
      if (i == 3) begin dmem_gnt = 1; dmem_rvalid = 0; end
      @(negedge clk);
    end
    dmem_gnt = 0; dmem_rdata = 0;
    for (int j = 0; j < 2; j++) begin
      checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_resp%0d: got req=%b v=%b ready=%b want 0/0/0", j, dmem_req, out_valid, in_ready); end
      @(negedge clk);
    end
    dmem_rvalid = 1; dmem_rdata = 32'h55AA_55AA; out_ready = 0;
    @(negedge clk);
    dmem_rvalid = 0; dmem_rdata = 0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || wdata_o !== 32'h55AA_55AA || wreg_o !== 5'd9 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold%0d: got v=%b wdata=%h wreg=%0d ready=%b want 1/55aa55aa/9/0", k, out_valid, wdata_o, wreg_o, in_ready); end
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got v=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_misalign();
    in_valid = 1; alu_result_i = 32'h0000_0101; load_type_i = 3'd2; wd_i = 1; wreg_i = 3;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b1 || misalign_o !== 1'b1 || wd_o !== 1'b0 || wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL mis_lh: got req=%b v=%b mis=%b wd=%b wdata=%h want 0/1/1/0/0", dmem_req, out_valid, misalign_o, wd_o, wdata_o); end
    load_type_i = 0; mem_wen_i = 1; store_type_i = 2'd3; alu_result_i = 32'h0000_0202; wd_i = 0;
    @(negedge clk);
    in_valid = 0; mem_wen_i = 0; store_type_i = 0;
    checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b1 || misalign_o !== 1'b1) begin errors++; $display("[TB] FAIL mis_sw: got req=%b v=%b mis=%b want 0/1/1", dmem_req, out_valid, misalign_o); end
    @(negedge clk);
    checks++; if (misalign_o !== 1'b0 || out_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse: got mis=%b v=%b req=%b want 0/0/0", misalign_o, out_valid, dmem_req); end
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1; alu_result_i = 32'h0000_0800; load_type_i = 3'd3; wd_i = 1; wreg_i = 12;
    @(negedge clk);
    in_valid = 0; load_type_i = 0; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0 || wd_o !== 1'b0 || wreg_o !== 5'd0 || wdata_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out: got v=%b req=%b wd=%b wreg=%0d wdata=%h mis=%b want zeros", out_valid, dmem_req, wd_o, wreg_o, wdata_o, misalign_o); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wen !== 1'b0 || dmem_wstrb !== 4'h0) begin errors++; $display("[TB] FAIL rst_mid_bus: got addr=%h wen=%b wstrb=%b want zeros", dmem_addr, dmem_wen, dmem_wstrb); end
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    dmem_rvalid = 0; dmem_rdata = 0;
    checks++; if (out_valid !== 1'b0 || wdata_o !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_discard: got v=%b wdata=%h ready=%b want 0/0/1", out_valid, wdata_o, in_ready); end
  endtask

  initial begin
    $display("[TB] starting ysyx_22041211_lsu bench");
    test_reset();
    test_alu();
    test_back_to_back();
    test_store();
    test_load();
    test_stall_backpressure();
    test_misalign();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
